// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module : pong_pkg
// Brief  : Shared state encoding and constants for the Pong game controller.
// Rev    : 1.0  initial release
// ============================================================================
package pong_pkg;

  // Game state codes; the text overlay decodes these values directly
  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  // Refresh ticks arrive once per frame at this rate
  localparam int C_FRAME_HZ = 60;

  // Width of one BCD score digit
  localparam int C_BCD_W = 4;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/bcd_score_counter.sv
`default_nettype none
// ============================================================================
// Module : bcd_score_counter
// Brief  : Two-digit BCD up-counter with clear and saturation at 99.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_score_counter
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [C_BCD_W-1:0] d1,
  output logic [C_BCD_W-1:0] d0
);

  logic [C_BCD_W-1:0] r_d1;
  logic [C_BCD_W-1:0] r_d0;

  // Clear wins over increment; 99 holds instead of wrapping to 00
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_d1 <= '0;
      r_d0 <= '0;
    end else if (inc) begin
      if (r_d0 == 4'd9) begin
        if (r_d1 != 4'd9) begin
          r_d0 <= '0;
          r_d1 <= r_d1 + 4'd1;
        end
      end else begin
        r_d0 <= r_d0 + 4'd1;
      end
    end
  end

  assign d1 = r_d1;
  assign d0 = r_d0;

endmodule : bcd_score_counter
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pong_game_ctrl
// Brief  : Pong game sequencer - ball hold/play, balls remaining, BCD score
//          and inter-ball / game-over pause timing.
// Rev    : 1.0  initial release
// ============================================================================
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_BALLS    = 3,
  parameter int TIMER_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       refr_tick,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] balls_left,
  output logic [1:0] game_state,
  output logic       game_over
);

  localparam logic [1:0] c_num_balls  = NUM_BALLS[1:0];
  localparam logic [6:0] c_timer_load = TIMER_FRAMES[6:0];

  state_t     r_state;
  logic [6:0] r_timer;
  logic [1:0] r_btn_prev;
  logic [1:0] r_balls;
  logic       r_gra_still;
  logic       r_game_over;

  logic       w_btn_start;
  logic       w_timer_done;
  logic       w_score_clr;
  logic       w_score_inc;

  // A rising edge on either button starts play; a held button does nothing
  assign w_btn_start  = |(btn & ~r_btn_prev);
  assign w_timer_done = (r_timer == 7'd0);

  // Score clears on the OVER->NEWGAME transition; a simultaneous miss cancels a hit
  assign w_score_clr = (r_state == OVER) && w_timer_done;
  assign w_score_inc = (r_state == PLAY) && hit && !miss;

  // Game sequencer, pause timer and ball counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= NEWGAME;
      r_timer     <= '0;
      r_btn_prev  <= 2'b00;
      r_balls     <= c_num_balls;
      r_gra_still <= 1'b1;
      r_game_over <= 1'b0;
    end else begin
      r_btn_prev <= btn;
      if (refr_tick && !w_timer_done) begin
        r_timer <= r_timer - 7'd1;
      end
      case (r_state)
        NEWGAME: begin
          if (w_btn_start) begin
            r_state     <= PLAY;
            r_balls     <= c_num_balls - 2'd1;
            r_gra_still <= 1'b0;
          end
        end
        PLAY: begin
          if (miss) begin
            // Entry load overrides any same-cycle tick decrement
            r_timer     <= c_timer_load;
            r_gra_still <= 1'b1;
            if (r_balls == 2'd0) begin
              r_state     <= OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state <= NEWBALL;
              r_balls <= r_balls - 2'd1;
            end
          end
        end
        NEWBALL: begin
          if (w_timer_done && w_btn_start) begin
            r_state     <= PLAY;
            r_gra_still <= 1'b0;
          end
        end
        OVER: begin
          if (w_timer_done) begin
            r_state     <= NEWGAME;
            r_game_over <= 1'b0;
            r_balls     <= c_num_balls;
          end
        end
        default: begin
          r_state <= NEWGAME;
        end
      endcase
    end
  end

  bcd_score_counter u_score (
    .clk (clk),
    .rst (reset),
    .clr (w_score_clr),
    .inc (w_score_inc),
    .d1  (score_d1),
    .d0  (score_d0)
  );

  assign gra_still  = r_gra_still;
  assign game_over  = r_game_over;
  assign balls_left = r_balls;
  assign game_state = r_state;

endmodule : pong_game_ctrl
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pong_game_ctrl
// Brief  : Directed self-checking bench for pong_game_ctrl (4-frame pauses).
// Rev    : 1.0  initial release
// ============================================================================
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn = 2'b00;
  logic       refr_tick = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       gra_still;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] balls_left;
  logic [1:0] game_state;
  logic       game_over;

  int n_cmp  = 0;
  int n_fail = 0;

  pong_game_ctrl #(
    .NUM_BALLS    (3),
    .TIMER_FRAMES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .refr_tick  (refr_tick),
    .hit        (hit),
    .miss       (miss),
    .gra_still  (gra_still),
    .score_d1   (score_d1),
    .score_d0   (score_d0),
    .balls_left (balls_left),
    .game_state (game_state),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  // One clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full visible status: state, still, score {d1,d0}, balls, game_over
  task automatic chk_all(input string tag, input logic [1:0] st, input logic still,
                         input logic [7:0] score, input logic [1:0] balls, input logic over);
    chk({tag, ".state"}, {6'd0, game_state}, {6'd0, st});
    chk({tag, ".still"}, {7'd0, gra_still}, {7'd0, still});
    chk({tag, ".score"}, {score_d1, score_d0}, score);
    chk({tag, ".balls"}, {6'd0, balls_left}, {6'd0, balls});
    chk({tag, ".over"}, {7'd0, game_over}, {7'd0, over});
  endtask

  task automatic pulse_hit(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1; step(); hit = 1'b0;
    end
  endtask

  task automatic pulse_miss();
    miss = 1'b1; step(); miss = 1'b0;
  endtask

  task automatic pulse_refr(input int n);
    for (int i = 0; i < n; i++) begin
      refr_tick = 1'b1; step(); refr_tick = 1'b0;
    end
  endtask

  task automatic press();
    btn = 2'b01; step(); btn = 2'b00; step();
  endtask

  initial begin
    // 1: reset and idle
    reset = 1'b1; step(2); reset = 1'b0;
    step(10);
    chk_all("reset_idle", 2'd0, 1'b1, 8'h00, 2'd3, 1'b0);

    // Stray hit/miss in NEWGAME must be ignored
    hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
    chk_all("newgame_ignore", 2'd0, 1'b1, 8'h00, 2'd3, 1'b0);

    // 2: held button starts once
    btn = 2'b01; step();
    chk_all("start", 2'd1, 1'b0, 8'h00, 2'd2, 1'b0);
    step(2);
    chk_all("held_btn", 2'd1, 1'b0, 8'h00, 2'd2, 1'b0);
    btn = 2'b00; step();

    // 3: scoring with BCD carry, then hit+miss together
    pulse_hit(9);
    chk("score_09", {score_d1, score_d0}, 8'h09);
    pulse_hit(3);
    chk("score_12", {score_d1, score_d0}, 8'h12);
    hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
    chk_all("hit_miss", 2'd2, 1'b1, 8'h12, 2'd1, 1'b0);

    // Hit outside PLAY ignored
    pulse_hit(1);
    chk("newball_hit", {score_d1, score_d0}, 8'h12);

    // 4: early button in NEWBALL ignored, accepted after 4th tick
    pulse_refr(2);
    press();
    chk("early_btn", {6'd0, game_state}, 8'd2);
    pulse_refr(2);
    chk("timer_zero_wait", {6'd0, game_state}, 8'd2);
    btn = 2'b10; step();
    chk_all("resume", 2'd1, 1'b0, 8'h12, 2'd1, 1'b0);
    btn = 2'b00; step();

    // 5: remaining balls lost -> OVER, then back to NEWGAME
    pulse_miss();
    chk_all("miss2", 2'd2, 1'b1, 8'h12, 2'd0, 1'b0);
    pulse_refr(4);
    btn = 2'b01; step(); btn = 2'b00;
    chk("resume2", {6'd0, game_state}, 8'd1);
    step();
    pulse_miss();
    chk_all("over", 2'd3, 1'b1, 8'h12, 2'd0, 1'b1);
    pulse_refr(3);
    chk_all("over_hold", 2'd3, 1'b1, 8'h12, 2'd0, 1'b1);
    pulse_refr(1);
    chk("over_last_tick", {6'd0, game_state}, 8'd3);
    step();
    chk_all("back_newgame", 2'd0, 1'b1, 8'h00, 2'd3, 1'b0);

    // Saturation at 99
    press();
    chk("start2", {6'd0, game_state}, 8'd1);
    pulse_hit(99);
    chk("score_99", {score_d1, score_d0}, 8'h99);
    pulse_hit(1);
    chk("score_sat", {score_d1, score_d0}, 8'h99);

    // 6: reset mid-PLAY with score 07 and one ball left
    reset = 1'b1; step(); reset = 1'b0;
    press();
    pulse_miss();
    pulse_refr(4);
    btn = 2'b01; step(); btn = 2'b00; step();
    pulse_hit(7);
    chk_all("pre_reset", 2'd1, 1'b0, 8'h07, 2'd1, 1'b0);
    pulse_miss();
    chk("timer_loaded", {1'b0, dut.r_timer}, 8'd4);
    reset = 1'b1; step(); reset = 1'b0;
    chk_all("mid_reset", 2'd0, 1'b1, 8'h00, 2'd3, 1'b0);
    chk("timer_cleared", {1'b0, dut.r_timer}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_pong_game_ctrl
`default_nettype wire
